tj_data_merger: RTL and testbench
=================================

Name: tj_data_merger

Overview:
- N-channel round-robin merger between several tjmono data receiver FIFOs and the single SRAM FIFO write port.
- Generalises the single-request arbiter path to N_CH channels.
- Adds burst lock via HOLD_REQ with a MAX_BURST cap, optional channel tagging, and one output register stage.
- Sustains one word per clock.

Parameters:
- N_CH, 2, number of input channels (1..16).
- DATA_W, 32, word width.
- MAX_BURST, 16, maximum words popped per locked grant; must be at least 1.
- CNT_W, 5, burst counter width; must be at least clog2(MAX_BURST+1).

Ports:
- CLK  in  1  merger clock (BUS_CLK domain).
- RST_N  in  1  asynchronous active-low reset.
- FIFO_EMPTY  in  N_CH  per-channel empty flag, first-word-fall-through.
- FIFO_DATA  in  N_CH*DATA_W  per-channel head word; channel i occupies bits [i*DATA_W +: DATA_W]; valid while its FIFO_EMPTY is low.
- FIFO_READ  out  N_CH  one-hot pop strobe, at most one bit high per cycle.
- HOLD_REQ  in  N_CH  per-channel burst lock request.
- READY_IN  in  1  sink accepts DATA_OUT this cycle.
- WRITE_OUT  out  1  DATA_OUT valid.
- DATA_OUT  out  DATA_W  merged word.
- GRANT_ID  out  4  channel of the word currently in DATA_OUT.
- LOCKED  out  1  burst lock active.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values:
  - WRITE_OUT=0, DATA_OUT=0, GRANT_ID=0, LOCKED=0, FIFO_READ=0.
  - Round-robin pointer LAST=N_CH-1, so channel 0 wins first.
  - Burst count 0.
  - Reset assertion mid-burst drops the output word; the un-popped source words stay in the source FIFOs.
- FIFO_READ is combinational from registered state and the EMPTY/HOLD/READY inputs.
- Output handshake:
  - FREE = !WRITE_OUT | READY_IN.
  - A transfer completes on WRITE_OUT & READY_IN.
  - DATA_OUT and GRANT_ID hold stable while WRITE_OUT & !READY_IN.
- Pop rule: FIFO_READ[c]=1 only if FREE, FIFO_EMPTY[c]=0, and c is the selected channel.
- Pop clock edge:
  - DATA_OUT <= FIFO_DATA[c], GRANT_ID <= c, WRITE_OUT <= 1.
  - Latency from pop to WRITE_OUT is 1 cycle.
- If FREE and there is no pop, WRITE_OUT <= 0.
- State ARB (LOCKED=0):
  - Selected channel is the first non-empty channel scanning LAST+1 .. LAST+N_CH, mod N_CH.
  - On a pop: LAST <= c and count <= 1.
  - If HOLD_REQ[c]=1 at the pop and MAX_BURST>1, go to LOCK with owner=c.
- State LOCK (LOCKED=1):
  - Selected channel is the owner only; other channels are never popped.
  - While the owner is empty: no pop, stay in LOCK, count unchanged.
  - Each pop increments count.
  - Exit to ARB at the edge where HOLD_REQ[owner]=0 (sampled any cycle), or after the pop that makes count==MAX_BURST.
  - The exit-cycle pop, if any, is still from the owner. Re-arbitration starts the next cycle from owner+1, which guarantees fairness.
  - Count resets to 0 on exit.
- Simultaneous events:
  - READY_IN on a full output register plus a pop in the same cycle is a back-to-back transfer with no bubble.
  - All channels non-empty without hold gives strict rotation 0,1,…,N_CH-1,0.
- N_CH=1 degenerates to a pass-through register with burst counting.

Optional Feature:
- MERGER_CH_TAG_EN defined: DATA_OUT[DATA_W-1 -: 4] is replaced by the channel index on load. The remaining DATA_W-4 bits come from the source unchanged.
- MERGER_CH_TAG_EN undefined: the word is passed unmodified, and channel identity is available only on GRANT_ID.

Decomposition:
- Package tj_merger_pkg holds:
  - state enum {ARB, LOCK};
  - localparam TAG_W=4;
  - function rr_pick(req, last), returning the next index.
- Sub-module rr_pick_n is natural: a combinational rotate–priority-encode–unrotate.
- Registers and the FSM stay in tj_data_merger.

Test Plan:
- Reset during an active LOCK burst (RST_N low for 2 cycles) -> WRITE_OUT=0, LOCKED=0, GRANT_ID=0 immediately; the first post-reset pop goes to channel 0.
- N_CH=3, all channels hold 4 words, HOLD_REQ=0, READY_IN=1 -> 12 consecutive WRITE_OUT cycles; GRANT_ID sequence 0,1,2 ×4; source word order preserved per channel.
- Channel 1 holds 40 words, HOLD_REQ[1]=1, channel 0 holds 5 words, MAX_BURST=16 -> 16 words from channel 1, then 1 from channel 0, then a relock on channel 1; LOCKED drops for exactly one cycle after each burst.
- READY_IN toggles 1,0,0,1 with data present -> DATA_OUT stable during the 0 cycles; no FIFO_READ while WRITE_OUT & !READY_IN; no word lost or duplicated.
- LOCK owner channel 2 goes empty for 5 cycles while channel 0 is non-empty -> no pops for those 5 cycles. Dropping HOLD_REQ[2] mid-gap -> ARB next cycle; channel 0 is popped the following cycle.
- MERGER_CH_TAG_EN build, channel 2 word 0x0ABCDEF1 -> DATA_OUT=0x2ABCDEF1, GRANT_ID=2.

Source files
------------

// File: rtl/tj_merger_pkg.sv
// rtl/tj_merger_pkg.sv - shared types and helpers for the tjmono data merger
//
// Purpose : arbiter state encoding, channel-tag width and a reference
//           round-robin pick function for up to 16 requesters.
// Ports   : none (package).
// Config  : the channel tag width is used by tj_data_merger when
//           MERGER_CH_TAG_EN is defined.
package tj_merger_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } state_t;

  localparam int TAG_W  = 4;
  localparam int MAX_CH = 16;

  // Scan last+1 .. last+n (mod n) and return the first requester found.
  // With no request the previous winner is returned unchanged.
  function automatic logic [3:0] rr_pick(input logic [MAX_CH-1:0] req,
                                         input logic [3:0]        last,
                                         input int                n);
    logic found;
    int   idx;
    rr_pick = last;
    found   = 1'b0;
    for (int i = 1; i <= MAX_CH; i++) begin
      idx = (int'(last) + i) % ((n < 1) ? 1 : n);
      if (!found && (i <= n) && req[idx[3:0]]) begin
        rr_pick = idx[3:0];
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/tj_data_merger_rr_pick_n.sv
// rtl/tj_data_merger_rr_pick_n.sv - combinational round-robin picker
//
// Purpose : rotate the request vector so last+1 sits at bit 0, priority
//           encode the lowest set bit, then rotate the index back.
// Ports   : req  in  N   request per channel
//           last in  IW  previous winner (always < N)
//           pick out IW  selected channel (== last when nothing requests)
//           any  out 1   at least one request present
module rr_pick_n #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] pick,
  output logic          any
);

  localparam int IW1 = IW + 1;

  logic [N-1:0]   rot;
  logic [IW-1:0]  pe;
  logic [IW1-1:0] idx;

  always_comb begin
    rot  = '0;
    pe   = '0;
    idx  = '0;
    any  = 1'b0;
    pick = last;

    // Rotate: rot[i] = req[(last + 1 + i) mod N]; the sum stays below 2N,
    // so one conditional subtract is enough for the wrap.
    for (int i = 0; i < N; i++) begin
      idx = {1'b0, last} + IW1'(i + 1);
      if (idx >= IW1'(N)) idx = idx - IW1'(N);
      for (int j = 0; j < N; j++) begin
        if (idx == IW1'(j)) rot[i] = req[j];
      end
    end

    for (int i = 0; i < N; i++) begin
      if (!any && rot[i]) begin
        any = 1'b1;
        pe  = IW'(i);
      end
    end

    // Unrotate the encoded position back to a channel index.
    idx = {1'b0, last} + IW1'(1) + {1'b0, pe};
    if (idx >= IW1'(N)) idx = idx - IW1'(N);
    if (any) pick = idx[IW-1:0];
  end

endmodule

// File: rtl/tj_data_merger.sv
// rtl/tj_data_merger.sv - N-channel round-robin merger into the SRAM FIFO write port
//
// Purpose : pops first-word-fall-through receiver FIFOs round-robin, with a
//           per-channel burst lock (HOLD_REQ, capped at MAX_BURST words) and
//           one output register stage; sustains one word per clock.
// Ports   : CLK         in  1          merger clock
//           RST_N       in  1          asynchronous active-low reset
//           FIFO_EMPTY  in  N_CH       per-channel empty flag
//           FIFO_DATA   in  N_CH*DATA_W per-channel head word, channel i at [i*DATA_W +: DATA_W]
//           FIFO_READ   out N_CH       one-hot pop strobe
//           HOLD_REQ    in  N_CH       per-channel burst lock request
//           READY_IN    in  1          sink accepts DATA_OUT
//           WRITE_OUT   out 1          DATA_OUT valid
//           DATA_OUT    out DATA_W     merged word
//           GRANT_ID    out 4          channel of the word in DATA_OUT
//           LOCKED      out 1          burst lock active
// Config  : MERGER_CH_TAG_EN - when defined, the top TAG_W bits of each
//           loaded word are replaced by the source channel index.
module tj_data_merger
  import tj_merger_pkg::*;
#(
  parameter int N_CH      = 2,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 16,
  parameter int CNT_W     = 5
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic [N_CH-1:0]        FIFO_EMPTY,
  input  logic [N_CH*DATA_W-1:0] FIFO_DATA,
  output logic [N_CH-1:0]        FIFO_READ,
  input  logic [N_CH-1:0]        HOLD_REQ,
  input  logic                   READY_IN,
  output logic                   WRITE_OUT,
  output logic [DATA_W-1:0]      DATA_OUT,
  output logic [3:0]             GRANT_ID,
  output logic                   LOCKED
);

  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   last_q, last_d;   // last winner; doubles as lock owner
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;

  logic               write_q;
  logic [DATA_W-1:0]  data_q;
  logic [3:0]         gid_q;

  logic [IDX_W-1:0]   arb_pick;
  logic               arb_any;
  logic [IDX_W-1:0]   sel;
  logic               sel_empty, sel_hold, sel_ok;
  logic [DATA_W-1:0]  sel_data, load_word;
  logic               free, pop;

  rr_pick_n #(
    .N  (N_CH),
    .IW (IDX_W)
  ) u_pick (
    .req  (~FIFO_EMPTY),
    .last (last_q),
    .pick (arb_pick),
    .any  (arb_any)
  );

  // Datapath select and pop strobe.
  always_comb begin
    free      = !write_q || READY_IN;
    sel       = (state_q == LOCK) ? last_q : arb_pick;
    sel_empty = 1'b1;
    sel_hold  = 1'b0;
    sel_data  = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (sel == IDX_W'(c)) begin
        sel_empty = FIFO_EMPTY[c];
        sel_hold  = HOLD_REQ[c];
        sel_data  = FIFO_DATA[c*DATA_W +: DATA_W];
      end
    end
    sel_ok = (state_q == LOCK) ? !sel_empty : arb_any;
    // Gated by RST_N so nothing leaves the source FIFOs while in reset.
    pop = free && sel_ok && RST_N;

    FIFO_READ = '0;
    for (int c = 0; c < N_CH; c++) begin
      FIFO_READ[c] = pop && (sel == IDX_W'(c));
    end

`ifdef MERGER_CH_TAG_EN
    load_word = {TAG_W'(sel), sel_data[DATA_W-TAG_W-1:0]};
`else
    load_word = sel_data;
`endif
  end

  // Arbiter / burst-lock next state.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    cnt_inc = cnt_q + CNT_W'(1);
    case (state_q)
      ARB: begin
        if (pop) begin
          last_d = sel;
          cnt_d  = CNT_W'(1);
          if (sel_hold && (MAX_BURST > 1)) state_d = LOCK;
        end
      end
      LOCK: begin
        if (pop) cnt_d = cnt_inc;
        // Owner releases, or this pop fills the burst: back to arbitration
        // starting from owner+1 so other channels get their turn.
        if (!sel_hold || (pop && (cnt_inc == CNT_W'(MAX_BURST)))) begin
          state_d = ARB;
          cnt_d   = '0;
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ARB;
      last_q  <= IDX_W'(N_CH - 1);
      cnt_q   <= '0;
      write_q <= 1'b0;
      data_q  <= '0;
      gid_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      if (pop) begin
        write_q <= 1'b1;
        data_q  <= load_word;
        gid_q   <= 4'(sel);
      end else if (free) begin
        write_q <= 1'b0;
      end
    end
  end

  assign WRITE_OUT = write_q;
  assign DATA_OUT  = data_q;
  assign GRANT_ID  = gid_q;
  assign LOCKED    = (state_q == LOCK);

endmodule

// File: tb/tb_tj_data_merger.sv
// tb/tb_tj_data_merger.sv - scoreboard bench for tj_data_merger (N_CH=3)
module tb_tj_data_merger;

  localparam int N = 3;
  localparam int W = 32;

  logic           CLK = 1'b0;
  logic           RST_N;
  logic [N-1:0]   FIFO_EMPTY;
  logic [N*W-1:0] FIFO_DATA;
  logic [N-1:0]   FIFO_READ;
  logic [N-1:0]   HOLD_REQ;
  logic           READY_IN;
  logic           WRITE_OUT;
  logic [W-1:0]   DATA_OUT;
  logic [3:0]     GRANT_ID;
  logic           LOCKED;

  always #5 CLK = ~CLK;

  tj_data_merger #(.N_CH(N), .DATA_W(W), .MAX_BURST(16), .CNT_W(5)) dut (
    .CLK(CLK), .RST_N(RST_N), .FIFO_EMPTY(FIFO_EMPTY), .FIFO_DATA(FIFO_DATA),
    .FIFO_READ(FIFO_READ), .HOLD_REQ(HOLD_REQ), .READY_IN(READY_IN),
    .WRITE_OUT(WRITE_OUT), .DATA_OUT(DATA_OUT), .GRANT_ID(GRANT_ID), .LOCKED(LOCKED)
  );

  typedef struct { logic [3:0] ch; logic [31:0] data; } exp_t;
  typedef struct { string name; logic [31:0] act; logic [31:0] req; } chk_t;

  logic [31:0] q0[$], q1[$], q2[$];
  exp_t        exp_q[$];
  chk_t        chk_q[$];

  int n_cmp = 0;
  int n_err = 0;

  logic [N-1:0] rd_snap;
  logic         lk_snap, wo_snap;

  function automatic logic [31:0] wd(int t, int c, int k);
    return {4'h0, 4'(t), 8'h00, 8'(c), 8'(k)};
  endfunction

  task automatic push_exp_word(int c, logic [31:0] d);
    exp_t e;
    e.ch   = 4'(c);
    e.data = d;
`ifdef MERGER_CH_TAG_EN
    e.data[31:28] = 4'(c);
`endif
    exp_q.push_back(e);
  endtask

  task automatic push_exp(int t, int c, int k);
    push_exp_word(c, wd(t, c, k));
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    chk_t ck;
    ck.name = name;
    ck.act  = act;
    ck.req  = req;
    chk_q.push_back(ck);
  endtask

  task automatic push_src(int c, logic [31:0] d);
    case (c)
      0: q0.push_back(d);
      1: q1.push_back(d);
      default: q2.push_back(d);
    endcase
  endtask

  task automatic refresh();
    FIFO_EMPTY[0] = (q0.size() == 0);
    FIFO_EMPTY[1] = (q1.size() == 0);
    FIFO_EMPTY[2] = (q2.size() == 0);
    FIFO_DATA[W-1:0]     = (q0.size() == 0) ? '0 : q0[0];
    FIFO_DATA[2*W-1:W]   = (q1.size() == 0) ? '0 : q1[0];
    FIFO_DATA[3*W-1:2*W] = (q2.size() == 0) ? '0 : q2[0];
  endtask

  // One clock: snapshot the cycle's strobes at the falling edge, then apply
  // the pops to the source model just after the rising edge.
  task automatic step();
    @(negedge CLK);
    rd_snap = FIFO_READ;
    lk_snap = LOCKED;
    wo_snap = WRITE_OUT;
    @(posedge CLK);
    #1;
    if (rd_snap[0] && q0.size() > 0) void'(q0.pop_front());
    if (rd_snap[1] && q1.size() > 0) void'(q1.pop_front());
    if (rd_snap[2] && q2.size() > 0) void'(q2.pop_front());
    refresh();
  endtask

  task automatic do_reset();
    RST_N    = 1'b0;
    HOLD_REQ = '0;
    READY_IN = 1'b1;
    q0.delete();
    q1.delete();
    q2.delete();
    exp_q.delete();
    refresh();
    step();
    step();
    RST_N = 1'b1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    READY_IN = 1'b1;
    while (exp_q.size() != 0 && n < 300) begin
      step();
      n++;
    end
    check("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: the only place comparisons are counted.
  task automatic cmp(string name, logic [31:0] act, logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  initial begin : monitor
    chk_t        ck;
    exp_t        e;
    logic        prev_stall;
    logic [31:0] prev_data;
    logic [3:0]  prev_gid;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_gid   = '0;
    forever begin
      @(negedge CLK);
      while (chk_q.size() > 0) begin
        ck = chk_q.pop_front();
        cmp(ck.name, ck.act, ck.req);
      end
      if (RST_N !== 1'b1) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          cmp("stall_hold_data", DATA_OUT, prev_data);
          cmp("stall_hold_gid", 32'(GRANT_ID), 32'(prev_gid));
        end
        if (FIFO_READ != '0) cmp("read_onehot", 32'($countones(FIFO_READ)), 32'd1);
        if (WRITE_OUT && !READY_IN) cmp("stall_no_pop", 32'(FIFO_READ), 32'd0);
        if (WRITE_OUT && READY_IN) begin
          if (exp_q.size() == 0) begin
            cmp("unexpected_word", DATA_OUT, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            cmp("word_data", DATA_OUT, e.data);
            cmp("word_gid", 32'(GRANT_ID), 32'(e.ch));
          end
        end
        prev_stall = WRITE_OUT && !READY_IN;
        prev_data  = DATA_OUT;
        prev_gid   = GRANT_ID;
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    bit [9:0] rpat;
    int       cnt;

    RST_N = 1'b0;
    HOLD_REQ = '0;
    READY_IN = 1'b1;
    refresh();
    #1;
    check("rst_write_out", 32'(WRITE_OUT), 32'd0);
    check("rst_read", 32'(FIFO_READ), 32'd0);

    // 1: reset while channel 1 holds a burst lock.
    do_reset();
    HOLD_REQ = 3'b010;
    for (int k = 0; k < 6; k++) push_src(1, wd(1, 1, k));
    refresh();
    push_exp(1, 1, 0);
    push_exp(1, 1, 1);
    step();
    check("t1_first_pop", 32'(rd_snap), 32'b010);
    step();
    step();
    check("t1_locked", 32'(lk_snap), 32'd1);
    RST_N = 1'b0;
    #1;
    check("t1_rst_wo", 32'(WRITE_OUT), 32'd0);
    check("t1_rst_locked", 32'(LOCKED), 32'd0);
    check("t1_rst_gid", 32'(GRANT_ID), 32'd0);
    check("t1_rst_data", DATA_OUT, 32'd0);
    push_src(0, wd(1, 0, 0));
    refresh();
    step();
    check("t1_rst_no_pop", 32'(rd_snap), 32'd0);
    step();
    check("t1_q1_kept", 32'(q1.size()), 32'd3);
    RST_N = 1'b1;
    push_exp(1, 0, 0);
    push_exp(1, 1, 3);
    push_exp(1, 1, 4);
    push_exp(1, 1, 5);
    step();
    check("t1_post_rst_ch0", 32'(rd_snap), 32'b001);
    drain();

    // 2: strict rotation, 4 words per channel.
    do_reset();
    for (int c = 0; c < N; c++)
      for (int k = 0; k < 4; k++) push_src(c, wd(2, c, k));
    refresh();
    for (int k = 0; k < 4; k++)
      for (int c = 0; c < N; c++) push_exp(2, c, k);
    step();
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (wo_snap) cnt++;
    end
    check("t2_wo_cycles", 32'(cnt), 32'd12);
    drain();

    // 3: channel 1 burst lock capped at 16, channel 0 interleaved.
    do_reset();
    HOLD_REQ = 3'b010;
    for (int k = 0; k < 40; k++) push_src(1, wd(3, 1, k));
    for (int k = 0; k < 5; k++) push_src(0, wd(3, 0, k));
    refresh();
    push_exp(3, 0, 0);
    for (int k = 0; k < 16; k++) push_exp(3, 1, k);
    push_exp(3, 0, 1);
    for (int k = 16; k < 32; k++) push_exp(3, 1, k);
    push_exp(3, 0, 2);
    for (int k = 32; k < 40; k++) push_exp(3, 1, k);
    push_exp(3, 0, 3);
    push_exp(3, 0, 4);
    for (int i = 0; i < 50; i++) step();
    check("t3_starve_pop", 32'(rd_snap), 32'd0);
    check("t3_starve_locked", 32'(lk_snap), 32'd1);
    check("t3_q0_left", 32'(q0.size()), 32'd2);
    HOLD_REQ = 3'b000;
    drain();

    // 4: READY_IN back-pressure.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      push_src(0, wd(4, 0, k));
      push_exp(4, 0, k);
    end
    refresh();
    rpat = 10'b1111101001;   // applied LSB first: 1,0,0,1,0,1,1,1,1,1
    for (int i = 0; i < 10; i++) begin
      READY_IN = rpat[i];
      step();
    end
    drain();

    // 5: lock owner empty gap, then release.
    do_reset();
    HOLD_REQ = 3'b100;
    push_src(2, wd(5, 2, 0));
    push_src(2, wd(5, 2, 1));
    refresh();
    push_exp(5, 2, 0);
    push_exp(5, 2, 1);
    step();
    check("t5_first_pop", 32'(rd_snap), 32'b100);
    for (int k = 0; k < 3; k++) begin
      push_src(0, wd(5, 0, k));
      push_exp(5, 0, k);
    end
    refresh();
    step();
    check("t5_second_pop", 32'(rd_snap), 32'b100);
    for (int i = 0; i < 5; i++) begin
      step();
      check("t5_gap_no_pop", 32'(rd_snap), 32'd0);
      check("t5_gap_locked", 32'(lk_snap), 32'd1);
    end
    HOLD_REQ = 3'b000;
    step();
    step();
    check("t5_arb_locked", 32'(lk_snap), 32'd0);
    check("t5_arb_pop_ch0", 32'(rd_snap), 32'b001);
    drain();

    // 6: channel tag (word passes unmodified in the default build).
    do_reset();
    push_src(2, 32'h0ABC_DEF1);
    refresh();
    push_exp_word(2, 32'h0ABC_DEF1);
    drain();

    step();
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
